// File: rtl/fifo_periph_pkg.sv
// Shared constants for the APB FIFO peripheral: register addresses,
// status bit positions and default geometry.
package fifo_periph_pkg;

    localparam logic [3:0] ADDR_FSR = 4'h0;
    localparam logic [3:0] ADDR_FWD = 4'h4;
    localparam logic [3:0] ADDR_FRD = 4'h8;

    localparam int unsigned EMPTY_BIT = 0;
    localparam int unsigned FULL_BIT  = 1;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_DWIDTH = 8;

endpackage

// File: rtl/fifo_core.sv
// Synchronous circular-buffer FIFO with extra-MSB pointers for full/empty
// discrimination and a combinational read port at the head entry.
module fifo_core
    import fifo_periph_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Status flags and qualified push/pop; a push into a full FIFO is allowed
    // only when a pop frees the head slot in the same cycle.
    always_comb begin
        empty = (rd_ptr == wr_ptr);
        full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || rd_en);
        rdata = mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fifo_periph.sv
// APB slave exposing a byte FIFO through FSR (status), FWD (push/pop port)
// and FRD (last popped byte). Zero wait states.
module fifo_periph
    import fifo_periph_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY
);

    logic              access;
    logic              sel_fwd;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] frd;
    logic [31:0]       fsr;
    logic              unused_ok;

    assign unused_ok = ^{PADDR[1:0], PWDATA};

    // APB decode and single-shot push/pop generation in the access cycle.
    always_comb begin
        PREADY  = PSEL && PENABLE;
        access  = PSEL && PENABLE && PREADY;
        sel_fwd = (PADDR[3:2] == ADDR_FWD[3:2]);
        wr_en   = access && PWRITE && sel_fwd && !full;
        rd_en   = access && !PWRITE && sel_fwd && !empty;
    end

    fifo_core #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_core (
        .clk   (PCLK),
        .reset (PRESET),
        .wr_en (wr_en),
        .wdata (PWDATA[DWIDTH-1:0]),
        .rd_en (rd_en),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // FRD captures the head entry on every successful pop.
    always_ff @(posedge PCLK) begin
        if (PRESET)     frd <= '0;
        else if (rd_en) frd <= head;
    end

    // Read data mux; driven only during read transfers, zero otherwise.
    always_comb begin
        fsr            = '0;
        fsr[EMPTY_BIT] = empty;
        fsr[FULL_BIT]  = full;
        PRDATA         = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR[3:2])
                ADDR_FSR[3:2]: PRDATA = fsr;
                ADDR_FRD[3:2]: PRDATA = 32'(frd);
                default:       PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_periph.sv
// Scoreboard bench for fifo_periph: stimulus tasks update a queue-based
// reference model and enqueue expected read data; a monitor compares.
module tb_fifo_periph;

    localparam int unsigned DEPTH = 4;

    logic        PCLK;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    fifo_periph #(.DEPTH(DEPTH), .DWIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Reference model: FIFO contents as a queue plus the last popped byte.
    logic [7:0]  model_q [$];
    logic [7:0]  frd_m;

    // Scoreboard.
    logic [31:0] exp_q  [$];
    string       name_q [$];
    int          checks   = 0;
    int          failures = 0;

    // Monitor: every read access cycle must match the next expectation.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PWRITE && !PRESET) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read got=%h required=none", PRDATA);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (PRDATA !== e || PREADY !== 1'b1) begin
                    failures++;
                    $display("FAIL %s got=%h ready=%b required=%h ready=1", n, PRDATA, PREADY, e);
                end
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
        if (addr[3:2] == 2'd1 && model_q.size() < DEPTH) model_q.push_back(data[7:0]);
        apb_xfer(1'b1, addr, data);
    endtask

    task automatic rd_reg(input logic [3:0] addr, input string nm);
        logic [31:0] e;
        case (addr[3:2])
            2'd0:    e = {30'b0, model_q.size() == DEPTH, model_q.size() == 0};
            2'd2:    e = {24'b0, frd_m};
            default: e = 32'h0;
        endcase
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (addr[3:2] == 2'd1 && model_q.size() > 0) frd_m = model_q.pop_front();
        apb_xfer(1'b0, addr, 32'h0);
    endtask

    task automatic model_reset();
        model_q.delete();
        frd_m = 8'h00;
    endtask

    initial begin
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        PRESET = 1'b1;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Reset state.
        rd_reg(4'h0, "reset_fsr");
        rd_reg(4'h8, "reset_frd");

        // Basic push/pop.
        wr_reg(4'h4, 32'hAA);
        wr_reg(4'h4, 32'hBB);
        rd_reg(4'h4, "pop_ret0");
        rd_reg(4'h8, "frd_aa");
        rd_reg(4'h4, "pop_ret0");
        rd_reg(4'h8, "frd_bb");
        rd_reg(4'h0, "fsr_empty");

        // Fill, overflow drop, drain.
        for (int i = 1; i <= 4; i++) wr_reg(4'h4, 32'(i * 8'h11));
        rd_reg(4'h0, "fsr_full");
        wr_reg(4'h4, 32'h55);
        rd_reg(4'h0, "fsr_full_after_drop");
        for (int i = 0; i < 4; i++) begin
            rd_reg(4'h4, "drain_pop");
            rd_reg(4'h8, "drain_frd");
        end
        rd_reg(4'h0, "fsr_drained");

        // Underflow leaves FRD unchanged.
        rd_reg(4'h4, "underflow_pop");
        rd_reg(4'h8, "underflow_frd");
        rd_reg(4'h0, "underflow_fsr");

        // Wrap-around.
        for (int r = 0; r < 6; r++) begin
            wr_reg(4'h4, 32'(2 * r + 1));
            wr_reg(4'h4, 32'(2 * r + 2));
            rd_reg(4'h0, "wrap_fsr");
            for (int k = 0; k < 2; k++) begin
                rd_reg(4'h4, "wrap_pop");
                rd_reg(4'h8, "wrap_frd");
            end
        end

        // Reset mid-fill, with a write aborted in its access cycle.
        wr_reg(4'h4, 32'hC1);
        wr_reg(4'h4, 32'hC2);
        rd_reg(4'h4, "prereset_pop");
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        model_reset();
        rd_reg(4'h0, "postreset_fsr");
        rd_reg(4'h8, "postreset_frd");
        wr_reg(4'h4, 32'h77);
        rd_reg(4'h4, "postreset_pop");
        rd_reg(4'h8, "postreset_frd77");

        // Randomized traffic, including ignored writes and don't-care PADDR[1:0].
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic [3:0]  a;
            op = $urandom_range(0, 9);
            a  = {2'(op % 4), 2'($urandom_range(0, 3))};
            if (op < 4)      wr_reg({2'd1, a[1:0]}, $urandom);
            else if (op < 6) rd_reg({2'd1, a[1:0]}, "rnd_pop");
            else if (op < 8) rd_reg({2'(op - 6) * 2'd2, a[1:0]}, "rnd_status");
            else if (op < 9) wr_reg({2'(op % 3) * 2'd2 + 2'd0, a[1:0]}, $urandom);
            else             rd_reg({2'd3, a[1:0]}, "rnd_unmapped");
            repeat ($urandom_range(0, 2)) @(posedge PCLK);
        end

        // Let the monitor drain outstanding expectations, bounded.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge PCLK);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
